cpu_machinectl: RTL and testbench

//  Multi-cycle control FSM that drives the ALU/accumulator datapath of the RISC CPU.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/ctl_decode.sv | 51 +++++
 rtl/cpu_machinectl.sv | 83 ++++++++
 tb/tb_cpu_machinectl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map (common with the ALU), controller
// state encodings, control-word layout and opcode class decode.
package cpu_pkg;

   localparam int OP_W = 4;
   localparam int ST_W = 3;

   localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
   localparam logic [OP_W-1:0] OP_LDO  = 4'b0001;
   localparam logic [OP_W-1:0] OP_LDA  = 4'b0010;
   localparam logic [OP_W-1:0] OP_STO  = 4'b0011;
   localparam logic [OP_W-1:0] OP_PRE  = 4'b0100;
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0101;
   localparam logic [OP_W-1:0] OP_LDM  = 4'b0110;
   localparam logic [OP_W-1:0] OP_HLT  = 4'b0111;
   localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
   localparam logic [OP_W-1:0] OP_OR   = 4'b1001;
   localparam logic [OP_W-1:0] OP_SLEF = 4'b1010;
   localparam logic [OP_W-1:0] OP_SRIG = 4'b1011;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b1100;
   localparam logic [OP_W-1:0] OP_INC  = 4'b1101;
   localparam logic [OP_W-1:0] OP_DEC  = 4'b1110;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b1111;

   typedef enum logic [ST_W-1:0] {
      S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
      S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
   } state_t;

   // RD: reads an operand, WB: writes back, UN: unary on acc,
   // NP: no-op, H: halt, X: unimplemented
   typedef enum logic [2:0] {
      CL_RD, CL_WB, CL_UN, CL_NP, CL_H, CL_X
   } op_class_t;

   typedef struct packed {
      logic inc_pc;
      logic load_ir;
      logic rd;
      logic wr;
      logic load_acc;
      logic datactl_ena;
      logic halt;
      logic illegal;
   } ctl_t;

   function automatic op_class_t op_class(input logic [OP_W-1:0] op);
      op_class_t c;
      case (op)
         OP_STO, OP_LDM:   c = CL_WB;
         OP_INC, OP_DEC:   c = CL_UN;
         OP_NOP:           c = CL_NP;
         OP_HLT:           c = CL_H;
         OP_SLEF, OP_SRIG: c = CL_X;
         default:          c = CL_RD;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational control decode: (state, opcode) -> control word.
module ctl_decode
   import cpu_pkg::*;
(
   input  state_t          state,
   input  logic [OP_W-1:0] op,
   output ctl_t            ctl
);

   op_class_t cls;
   assign cls = op_class(op);

   // per-state strobe decode; anything not set stays 0
   always_comb begin
      ctl = '0;
      case (state)
         S0: begin
            ctl.rd      = 1'b1;
            ctl.load_ir = 1'b1;
         end
         S1: begin
            ctl.rd      = 1'b1;
            ctl.load_ir = 1'b1;
            ctl.inc_pc  = 1'b1;
         end
         S3: begin
            if (cls == CL_H) begin
               ctl.halt = 1'b1;
            end else begin
               ctl.inc_pc  = 1'b1;
               ctl.illegal = (cls == CL_X);
            end
         end
         S4: begin
            ctl.rd          = (cls == CL_RD);
            ctl.datactl_ena = (cls == CL_WB);
         end
         S5: begin
            ctl.rd          = (cls == CL_RD);
            ctl.load_acc    = (cls == CL_RD) || (cls == CL_UN);
            ctl.wr          = (cls == CL_WB);
            ctl.datactl_ena = (cls == CL_WB);
         end
         S6: begin
            ctl.datactl_ena = (cls == CL_WB);
         end
         default: ctl = '0;
      endcase
   end

endmodule

// File: rtl/cpu_machinectl.sv
// Eight-state fetch/decode/execute controller for the accumulator CPU.
// Output registers load the decode of the state being entered, so the
// strobes visible in a cycle belong to the current state.
module cpu_machinectl
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic [OP_W-1:0] opcode,
   output logic            inc_pc,
   output logic            load_ir,
   output logic            rd,
   output logic            wr,
   output logic            load_acc,
   output logic            datactl_ena,
   output logic            halt,
   output logic            illegal
);

   state_t          state, next_state;
   logic [OP_W-1:0] op_q, op_d;
   ctl_t            ctl_d, ctl_q, ctl_idle;
   logic            halted;

   // a halt parks the machine in S3 until reset, regardless of ena
   assign halted = (state == S3) && (op_class(op_q) == CL_H);

   // the decode for S3 must see the opcode being captured on this edge
   assign op_d = (state == S2) ? opcode : op_q;

   // sequential step through S0..S7, wrapping to S0
   always_comb begin
      next_state = S0;
      case (state)
         S0: next_state = S1;
         S1: next_state = S2;
         S2: next_state = S3;
         S3: next_state = S4;
         S4: next_state = S5;
         S5: next_state = S6;
         S6: next_state = S7;
         default: next_state = S0;
      endcase
   end

   // stalled/halted control word: strobes off, halt flag preserved
   always_comb begin
      ctl_idle      = '0;
      ctl_idle.halt = ctl_q.halt;
   end

   ctl_decode u_dec (
      .state (next_state),
      .op    (op_d),
      .ctl   (ctl_d)
   );

   // state, captured opcode and registered control outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S0;
         op_q  <= OP_NOP;
         ctl_q <= '0;
      end else if (halted || !ena) begin
         ctl_q <= ctl_idle;
      end else begin
         state <= next_state;
         op_q  <= op_d;
         ctl_q <= ctl_d;
      end
   end

   assign inc_pc      = ctl_q.inc_pc;
   assign load_ir     = ctl_q.load_ir;
   assign rd          = ctl_q.rd;
   assign wr          = ctl_q.wr;
   assign load_acc    = ctl_q.load_acc;
   assign datactl_ena = ctl_q.datactl_ena;
   assign halt        = ctl_q.halt;
   assign illegal     = ctl_q.illegal;

endmodule

// File: tb/tb_cpu_machinectl.sv
// Scoreboard bench for cpu_machinectl. Each stimulus step pushes the
// hand-computed control byte expected after its clock edge; a monitor
// pops and compares on the falling edge.
// Byte layout: {inc_pc, load_ir, rd, wr, load_acc, datactl_ena, halt, illegal}
module tb_cpu_machinectl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic [3:0] opcode = 4'b0000;
   logic       inc_pc, load_ir, rd, wr, load_acc, datactl_ena, halt, illegal;
   logic [7:0] obs;

   typedef struct {
      string      name;
      logic [7:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // expected bytes for S1,S2,S3,S4,S5,S6,S7,S0 of one instruction
   localparam logic [63:0] SEQ_RD = 64'hE0_00_80_20_28_00_00_60;
   localparam logic [63:0] SEQ_WB = 64'hE0_00_80_04_14_04_00_60;
   localparam logic [63:0] SEQ_UN = 64'hE0_00_80_00_08_00_00_60;
   localparam logic [63:0] SEQ_NP = 64'hE0_00_80_00_00_00_00_60;
   localparam logic [63:0] SEQ_X  = 64'hE0_00_81_00_00_00_00_60;

   cpu_machinectl dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .opcode      (opcode),
      .inc_pc      (inc_pc),
      .load_ir     (load_ir),
      .rd          (rd),
      .wr          (wr),
      .load_acc    (load_acc),
      .datactl_ena (datactl_ena),
      .halt        (halt),
      .illegal     (illegal)
   );

   assign obs = {inc_pc, load_ir, rd, wr, load_acc, datactl_ena, halt, illegal};

   always #5 clk = ~clk;

   // monitor: one expected byte per clock, plus rd/wr exclusion
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e.v) begin
               n_bad++;
               $display("FAIL %s: got %h expected %h at %0t", e.name, obs, e.v, $time);
            end
            n_cmp++;
            if (rd && wr) begin
               n_bad++;
               $display("FAIL rd_wr_overlap(%s): rd=%b wr=%b expected not both", e.name, rd, wr);
            end
         end
      end
   end

   task automatic step(input logic r, input logic e, input logic [3:0] op,
                       input logic [7:0] ex, input string nm);
      exp_t x;
      rst    = r;
      ena    = e;
      opcode = op;
      x.name = nm;
      x.v    = ex;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [3:0] op, input logic [63:0] seq, input string nm);
      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b1, op, seq[63-8*i -: 8], $sformatf("%s_c%0d", nm, i));
   endtask

   initial begin
      // reset held three cycles with ena high
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0000, 8'h00, "reset");
      // first pass after release runs as a NOP
      run_instr(4'b0000, SEQ_NP, "post_reset");
      run_instr(4'b0101, SEQ_RD, "add");
      run_instr(4'b0011, SEQ_WB, "sto");
      run_instr(4'b0110, SEQ_WB, "ldm");
      // SUB stalled for 5 cycles just before entering S4
      step(1'b1, 1'b1, 4'b1100, 8'hE0, "sub_s1");
      step(1'b1, 1'b1, 4'b1100, 8'h00, "sub_s2");
      step(1'b1, 1'b1, 4'b1100, 8'h80, "sub_s3");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'b1100, 8'h00, "sub_stall");
      step(1'b1, 1'b1, 4'b1100, 8'h20, "sub_s4");
      step(1'b1, 1'b1, 4'b1100, 8'h28, "sub_s5");
      step(1'b1, 1'b1, 4'b1100, 8'h00, "sub_s6");
      step(1'b1, 1'b1, 4'b1100, 8'h00, "sub_s7");
      step(1'b1, 1'b1, 4'b1100, 8'h60, "sub_s0");
      run_instr(4'b1010, SEQ_X, "slef");
      run_instr(4'b1011, SEQ_X, "srig");
      run_instr(4'b1111, SEQ_RD, "xor");
      run_instr(4'b0000, SEQ_NP, "nop");
      // INC aborted by reset on the edge into S4
      step(1'b1, 1'b1, 4'b1101, 8'hE0, "inc_s1");
      step(1'b1, 1'b1, 4'b1101, 8'h00, "inc_s2");
      step(1'b1, 1'b1, 4'b1101, 8'h80, "inc_s3");
      step(1'b0, 1'b1, 4'b1101, 8'h00, "inc_abort");
      run_instr(4'b1110, SEQ_UN, "dec");
      // HLT parks with halt=1 regardless of ena and opcode
      step(1'b1, 1'b1, 4'b0111, 8'hE0, "hlt_s1");
      step(1'b1, 1'b1, 4'b0111, 8'h00, "hlt_s2");
      step(1'b1, 1'b1, 4'b0111, 8'h02, "hlt_s3");
      for (int i = 0; i < 22; i++) begin
         logic [31:0] iv;
         iv = i;
         step(1'b1, iv[0], iv[3:0], 8'h02, "halted");
      end
      step(1'b0, 1'b1, 4'b0000, 8'h00, "halt_reset");
      step(1'b1, 1'b1, 4'b0000, 8'hE0, "refetch");
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
